// File: rtl/vga_sync_analyzer.sv
// Loopback checker for a VGA stream: measures sync timing, judges each frame, tracks lock.
// Define FRAME_CHECKSUM_EN to build the per-frame active-pixel checksum.
module vga_sync_analyzer #(
  parameter int unsigned H_TOTAL         = 800,
  parameter int unsigned H_SYNC          = 96,
  parameter int unsigned H_BACK          = 48,
  parameter int unsigned H_ACTIVE        = 640,
  parameter int unsigned V_TOTAL         = 525,
  parameter int unsigned V_SYNC          = 2,
  parameter int unsigned V_BACK          = 33,
  parameter int unsigned V_ACTIVE        = 480,
  parameter int unsigned SYNC_ACTIVE_LOW = 1,
  parameter int unsigned LOCK_FRAMES     = 2
) (
  input  logic        clock25MHz,
  input  logic        resetN,
  input  logic        hsyncIn,
  input  logic        vsyncIn,
  input  logic [3:0]  redIn,
  input  logic [3:0]  greenIn,
  input  logic [3:0]  blueIn,
  output logic [9:0]  hTotal,
  output logic [9:0]  hSyncWidth,
  output logic [9:0]  vTotal,
  output logic [9:0]  vSyncWidth,
  output logic        frameDone,
  output logic        frameGood,
  output logic        locked,
  output logic        noSignal,
  output logic [7:0]  errorCount,
  output logic [15:0] frameChecksum
);

  localparam logic       SyncLow    = (SYNC_ACTIVE_LOW != 0);
  localparam logic [9:0] CntMax     = 10'h3ff;
  localparam logic [9:0] HTotalExp  = 10'(H_TOTAL);
  localparam logic [9:0] HSyncExp   = 10'(H_SYNC);
  localparam logic [9:0] VTotalExp  = 10'(V_TOTAL);
  localparam logic [9:0] VSyncExp   = 10'(V_SYNC);
  localparam logic [4:0] LockFrames = 5'(LOCK_FRAMES);

  typedef enum logic [0:0] {StSearch, StLocked} lock_state_e;

  logic       hs_q, vs_q, hs_prev_q, vs_prev_q;
  logic [9:0] h_cnt_q, v_cnt_q;
  logic [9:0] h_total_q, h_sync_width_q, v_total_q, v_sync_width_q;
  logic       h_seen_q, armed_q, line_err_q, no_signal_q;
  logic       frame_done_q, frame_good_q, locked_q;
  logic [3:0] good_cnt_q;
  logic [7:0] err_cnt_q;
  lock_state_e state_q;

  logic       hs_rise, hs_fall, vs_rise, vs_fall;
  logic [9:0] h_cnt_inc;
  logic       h_err, sat, evaluate, frame_good_c;

  // Syncs are stored already normalised so that reset means "deasserted".
  always_ff @(posedge clock25MHz or negedge resetN) begin
    if (!resetN) begin
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      hs_prev_q <= 1'b0;
      vs_prev_q <= 1'b0;
    end else begin
      hs_q      <= hsyncIn ^ SyncLow;
      vs_q      <= vsyncIn ^ SyncLow;
      hs_prev_q <= hs_q;
      vs_prev_q <= vs_q;
    end
  end

  always_comb begin
    hs_rise      = hs_q & ~hs_prev_q;
    hs_fall      = ~hs_q & hs_prev_q;
    vs_rise      = vs_q & ~vs_prev_q;
    vs_fall      = ~vs_q & vs_prev_q;
    h_cnt_inc    = h_cnt_q + 10'd1;
    h_err        = (hs_rise && h_seen_q && (h_cnt_inc != HTotalExp)) ||
                   (hs_fall && (h_cnt_inc != HSyncExp));
    sat          = (h_cnt_q == CntMax) || (v_cnt_q == CntMax);
    evaluate     = vs_rise && armed_q;
    frame_good_c = !line_err_q && (v_cnt_q == VTotalExp) &&
                   (v_sync_width_q == VSyncExp) && !no_signal_q;
  end

  always_ff @(posedge clock25MHz or negedge resetN) begin
    if (!resetN) begin
      h_cnt_q        <= '0;
      v_cnt_q        <= '0;
      h_total_q      <= '0;
      h_sync_width_q <= '0;
      v_total_q      <= '0;
      v_sync_width_q <= '0;
      h_seen_q       <= 1'b0;
      armed_q        <= 1'b0;
      line_err_q     <= 1'b0;
      no_signal_q    <= 1'b0;
      frame_done_q   <= 1'b0;
      frame_good_q   <= 1'b0;
    end else begin
      if (hs_rise) begin
        h_cnt_q  <= '0;
        h_seen_q <= 1'b1;
        if (h_seen_q) h_total_q <= h_cnt_inc;
      end else if (h_cnt_q != CntMax) begin
        h_cnt_q <= h_cnt_inc;
      end
      if (hs_fall) h_sync_width_q <= h_cnt_inc;

      // A coincident hsync edge opens the new frame's first line.
      if (vs_rise) begin
        v_total_q <= v_cnt_q;
        v_cnt_q   <= hs_rise ? 10'd1 : 10'd0;
      end else if (hs_rise && (v_cnt_q != CntMax)) begin
        v_cnt_q <= v_cnt_q + 10'd1;
      end
      if (vs_fall) v_sync_width_q <= v_cnt_q;

      line_err_q   <= vs_rise ? h_err : (line_err_q | h_err);
      frame_done_q <= evaluate;
      if (evaluate) frame_good_q <= frame_good_c;

      if (vs_rise) begin
        armed_q     <= 1'b1;
        no_signal_q <= 1'b0;
      end
      // Loss of signal forgets the line reference and needs a fresh vsync to re-arm.
      if (sat) begin
        no_signal_q <= 1'b1;
        armed_q     <= 1'b0;
        h_seen_q    <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock25MHz or negedge resetN) begin
    if (!resetN) begin
      state_q    <= StSearch;
      good_cnt_q <= '0;
      locked_q   <= 1'b0;
      err_cnt_q  <= '0;
    end else if (sat) begin
      state_q    <= StSearch;
      good_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else if (evaluate) begin
      if (frame_good_c) begin
        unique case (state_q)
          StSearch: begin
            if ({1'b0, good_cnt_q} + 5'd1 >= LockFrames) begin
              state_q    <= StLocked;
              locked_q   <= 1'b1;
              good_cnt_q <= LockFrames[3:0];
            end else begin
              good_cnt_q <= good_cnt_q + 4'd1;
            end
          end
          StLocked: locked_q <= 1'b1;
        endcase
      end else begin
        state_q    <= StSearch;
        good_cnt_q <= '0;
        locked_q   <= 1'b0;
        if (err_cnt_q != 8'hff) err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

`ifdef FRAME_CHECKSUM_EN
  localparam logic [9:0] HStart = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] HEnd   = 10'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [9:0] VStart = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] VEnd   = 10'(V_SYNC + V_BACK + V_ACTIVE);

  logic [11:0] rgb_q;
  logic [15:0] csum_q, checksum_q;
  logic        active;

  assign active = (h_cnt_q >= HStart) && (h_cnt_q < HEnd) &&
                  (v_cnt_q >= VStart) && (v_cnt_q < VEnd);

  always_ff @(posedge clock25MHz or negedge resetN) begin
    if (!resetN) begin
      rgb_q      <= '0;
      csum_q     <= '0;
      checksum_q <= '0;
    end else begin
      rgb_q <= {redIn, greenIn, blueIn};
      if (vs_rise) begin
        checksum_q <= csum_q;
        csum_q     <= '0;
      end else if (active) begin
        csum_q <= {csum_q[14:0], csum_q[15]} ^ {4'h0, rgb_q};
      end
    end
  end

  assign frameChecksum = checksum_q;
`else
  logic unused_rgb_cfg;
  assign unused_rgb_cfg = ^{redIn, greenIn, blueIn, 10'(H_BACK), 10'(H_ACTIVE),
                            10'(V_BACK), 10'(V_ACTIVE)};
  assign frameChecksum  = '0;
`endif

  assign hTotal     = h_total_q;
  assign hSyncWidth = h_sync_width_q;
  assign vTotal     = v_total_q;
  assign vSyncWidth = v_sync_width_q;
  assign frameDone  = frame_done_q;
  assign frameGood  = frame_good_q;
  assign locked     = locked_q;
  assign noSignal   = no_signal_q;
  assign errorCount = err_cnt_q;

endmodule

// File: tb/tb_vga_sync_analyzer.sv
// Directed bench for vga_sync_analyzer using a scaled-down 40x12-line mode.
module tb_vga_sync_analyzer;
  localparam int HT = 40;
  localparam int HS = 6;
  localparam int VT = 12;
  localparam int VS = 2;
  localparam int NoLimit = 1000000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        hs_pin = 1'b1;
  logic        vs_pin = 1'b1;
  logic [3:0]  r = '0, g = '0, b = '0;
  logic [9:0]  hTotal, hSyncWidth, vTotal, vSyncWidth;
  logic        frameDone, frameGood, locked, noSignal;
  logic [7:0]  errorCount;
  logic [15:0] frameChecksum;

  int   vectors = 0;
  int   miscompares = 0;
  int   done_cnt = 0;
  logic last_good = 1'b0;
  int   exp_csum;

  vga_sync_analyzer #(
    .H_TOTAL(40), .H_SYNC(6), .H_BACK(4), .H_ACTIVE(24),
    .V_TOTAL(12), .V_SYNC(2), .V_BACK(3), .V_ACTIVE(6),
    .SYNC_ACTIVE_LOW(1), .LOCK_FRAMES(2)
  ) dut (
    .clock25MHz(clk), .resetN(rst_n), .hsyncIn(hs_pin), .vsyncIn(vs_pin),
    .redIn(r), .greenIn(g), .blueIn(b),
    .hTotal(hTotal), .hSyncWidth(hSyncWidth), .vTotal(vTotal), .vSyncWidth(vSyncWidth),
    .frameDone(frameDone), .frameGood(frameGood), .locked(locked), .noSignal(noSignal),
    .errorCount(errorCount), .frameChecksum(frameChecksum)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frameDone) begin
      done_cnt  <= done_cnt + 1;
      last_good <= frameGood;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // hs/vs are "asserted" flags; pins are active low.
  task automatic pix(input bit hs, input bit vs, input logic [11:0] rgb);
    @(negedge clk);
    hs_pin    = ~hs;
    vs_pin    = ~vs;
    {r, g, b} = rgb;
  endtask

  task automatic frame(input int stretch, input int voff, input int mark_line, input int limit);
    int idx = 0;
    for (int l = 0; l < VT; l++) begin
      int len = (l == stretch) ? HT + 1 : HT;
      for (int x = 0; x < len; x++) begin
        if (idx < limit)
          pix(x < HS, (idx >= voff) && (idx < voff + VS * HT),
              (l == mark_line && x == 34) ? 12'h001 : 12'h000);
        idx++;
      end
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_hTotal", 32'(hTotal), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_noSignal", 32'(noSignal), 0);
    check("rst_errorCount", 32'(errorCount), 0);
    check("rst_frameDone", 32'(frameDone), 0);
    rst_n = 1'b1;

    frame(-1, 0, -1, NoLimit);
    check("arm_no_done", done_cnt, 0);
    frame(-1, 0, -1, NoLimit);
    check("f1_done", done_cnt, 1);
    check("f1_good", 32'(last_good), 1);
    check("f1_not_locked", 32'(locked), 0);
    frame(-1, 0, -1, NoLimit);
    check("f2_done", done_cnt, 2);
    check("f2_locked", 32'(locked), 1);
    check("hTotal", 32'(hTotal), HT);
    check("hSyncWidth", 32'(hSyncWidth), HS);
    check("vTotal", 32'(vTotal), VT);
    check("vSyncWidth", 32'(vSyncWidth), VS);
    check("errorCount_clean", 32'(errorCount), 0);

    // Line 4 of this frame runs one clock long.
    frame(4, 0, -1, NoLimit);
    frame(-1, 0, -1, NoLimit);
    check("bad_done", done_cnt, 4);
    check("bad_good", 32'(last_good), 0);
    check("bad_unlocked", 32'(locked), 0);
    check("bad_errorCount", 32'(errorCount), 1);
    frame(-1, 0, -1, NoLimit);
    check("relock1_locked", 32'(locked), 0);
    frame(-1, 0, -1, NoLimit);
    check("relock2_done", done_cnt, 6);
    check("relock2_good", 32'(last_good), 1);
    check("relock2_locked", 32'(locked), 1);

    repeat (1100) pix(1'b0, 1'b0, 12'h000);
    check("nosig_set", 32'(noSignal), 1);
    check("nosig_unlocked", 32'(locked), 0);
    check("nosig_errorCount", 32'(errorCount), 1);
    check("nosig_no_done", done_cnt, 6);

    // Vsync now lands half a line after hsync.
    frame(-1, 20, -1, NoLimit);
    check("nosig_cleared", 32'(noSignal), 0);
    check("rearm_no_done", done_cnt, 6);
    frame(-1, 20, -1, NoLimit);
    check("offs_done", done_cnt, 7);
    check("offs_good", 32'(last_good), 1);
    check("offs_vTotal", 32'(vTotal), VT);
    check("offs_vSyncWidth", 32'(vSyncWidth), VS);
    frame(-1, 20, -1, NoLimit);
    check("offs_locked", 32'(locked), 1);
    check("offs_errorCount", 32'(errorCount), 1);

    frame(-1, 20, -1, 100);
    check("pre_rst_done", done_cnt, 9);
    #2 rst_n = 1'b0;
    #1;
    check("arst_hTotal", 32'(hTotal), 0);
    check("arst_hSyncWidth", 32'(hSyncWidth), 0);
    check("arst_vTotal", 32'(vTotal), 0);
    check("arst_vSyncWidth", 32'(vSyncWidth), 0);
    check("arst_locked", 32'(locked), 0);
    check("arst_errorCount", 32'(errorCount), 0);
    check("arst_noSignal", 32'(noSignal), 0);
    repeat (3) pix(1'b0, 1'b0, 12'h000);
    rst_n = 1'b1;

    frame(-1, 0, -1, NoLimit);
    check("post_rst_no_done", done_cnt, 9);
    frame(-1, 0, -1, NoLimit);
    check("post_rst_done", done_cnt, 10);
    check("post_rst_good", 32'(last_good), 1);
    // Single marked pixel is the last active one: hCnt 33, vCnt 10.
    frame(-1, 0, 9, NoLimit);
    check("post_rst_locked", 32'(locked), 1);
    frame(-1, 0, -1, NoLimit);
`ifdef FRAME_CHECKSUM_EN
    exp_csum = 1;
`else
    exp_csum = 0;
`endif
    check("csum_last_pixel", 32'(frameChecksum), exp_csum);
    frame(-1, 0, -1, NoLimit);
    check("csum_zero", 32'(frameChecksum), 0);
    check("final_done", done_cnt, 13);
    check("final_errorCount", 32'(errorCount), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
